// File: rtl/mem_pkg.sv
// Shared types and widths for the imem_responder slice.
//   XLEN_WORD : data word width (bits)
//   MASK_W    : byte-enable width (one bit per byte of a word)
//   state_e   : responder FSM states
//   mem_req_t : request bundle captured at the acceptance edge
package mem_pkg;

  localparam int XLEN_WORD = 64;
  localparam int MASK_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [63:0]          addr;
    logic [XLEN_WORD-1:0] wdata;
    logic [MASK_W-1:0]    wmask;
  } mem_req_t;

endpackage

// File: rtl/imem_responder_if.sv
// Request/response bus between the core memory port and imem_responder.
//   req_valid/req_ready : request handshake (master -> slave)
//   req_we/addr/wdata/wmask : request payload
//   resp_valid/resp_ready : response handshake (slave -> master)
//   rdata : read data, 0 for write responses
interface imem_responder_if;
  import mem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [63:0]          req_addr;
  logic [XLEN_WORD-1:0] req_wdata;
  logic [MASK_W-1:0]    req_wmask;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [XLEN_WORD-1:0] rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, rdata
  );

endinterface

// File: rtl/mem_word_array.sv
// Single-port byte-maskable word RAM with a registered read/holding register.
//   clk, rst  : clock, synchronous active-high reset (holding register only)
//   en_i      : access strobe (one per accepted request)
//   we_i      : 1 = write, 0 = read
//   idx_i     : word index
//   wdata_i   : write data, wmask_i : byte enables
//   rdata_o   : holding register; read word, or 0 after a write
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        idx_i,
  input  logic [XLEN_WORD-1:0] wdata_i,
  input  logic [MASK_W-1:0]    wmask_i,
  output logic [XLEN_WORD-1:0] rdata_o
);

  logic [XLEN_WORD-1:0] mem_q [DEPTH];
  logic [XLEN_WORD-1:0] rdata_q;

  // Array contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Only loaded on an access, so it holds through WAIT/RESP and after the handshake.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (en_i) rdata_q <= we_i ? '0 : mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: one request at a time, response after LATENCY cycles,
// held until the core accepts it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_responder_if.slave (request/response handshake + data)
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request done in the array, counting out remaining latency
// RESP  | resp_valid=1, rdata held until resp_ready
module imem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  imem_responder_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mem_req_t   req_s;
  logic       accept;
  logic       unused_addr;

  assign req_s = '{we: bus.req_we, addr: bus.req_addr,
                   wdata: bus.req_wdata, wmask: bus.req_wmask};

  // Upper address bits wrap; low three select a byte within the word.
  assign unused_addr = ^{req_s.addr[63:3+AW], req_s.addr[2:0]};

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP);
  assign accept         = bus.req_valid && bus.req_ready;

  mem_word_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept),
    .we_i    (req_s.we),
    .idx_i   (req_s.addr[3 +: AW]),
    .wdata_i (req_s.wdata),
    .wmask_i (req_s.wmask),
    .rdata_o (bus.rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // Counter value 1 means this is the last waiting cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
